// File: rtl/wvb_reader.sv
// wvb_reader: waveform buffer readout stage.
// Pops one header, sends it as 16-bit words, then streams the event's samples.
`timescale 1ns/1ps
module wvb_reader #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_HDR_WIDTH  = 80,
  parameter int P_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
  output logic                    wvb_rddone,
  output logic [15:0]             dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic                    busy
);

  localparam int NW = P_HDR_WIDTH / 16;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int CW = P_ADR_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_WAIT,
    S_HDR_SEND,
    S_DATA_ADDR,
    S_DATA_WAIT,
    S_DATA_SEND,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [P_HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic [P_ADR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [KW-1:0]           k_q, k_d;
  logic [P_DATA_WIDTH-1:0] smp_q, smp_d;

  logic                   start_ev;
  logic                   xfer;
  logic                   last_k;
  logic                   last_smp;
  logic [P_ADR_WIDTH-1:0] hdr_start;
  logic [P_ADR_WIDTH-1:0] hdr_stop;
  logic [CW-1:0]          nwords;
  logic [15:0]            hdr_word;

  assign start_ev  = en & ~hdr_empty;
  assign hdr_stop  = hdr_data[P_ADR_WIDTH-1:0];
  assign hdr_start = hdr_data[2*P_ADR_WIDTH-1:P_ADR_WIDTH];

  // Event length: modular distance plus one, so stop==start-1 is a full buffer.
  assign nwords = {1'b0, hdr_stop - hdr_start} + CW'(1);

  assign xfer = dout_valid & dout_ready;

  assign last_k   = (k_q == KW'(NW - 1));
  assign last_smp = (cnt_q == CW'(1));

  // Header words go out MSB slice first.
  assign hdr_word = 16'(hdr_q >> ((NW - 1 - int'(k_q)) * 16));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_ev) state_d = S_HDR_WAIT;
      end
      S_HDR_WAIT: begin
        state_d = S_HDR_SEND;
      end
      S_HDR_SEND: begin
        if (xfer && last_k) state_d = S_DATA_ADDR;
      end
      S_DATA_ADDR: begin
        state_d = S_DATA_WAIT;
      end
      S_DATA_WAIT: begin
        state_d = S_DATA_SEND;
      end
      S_DATA_SEND: begin
        if (xfer) state_d = last_smp ? S_DONE : S_DATA_ADDR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    hdr_rdreq  = 1'b0;
    wvb_rddone = 1'b0;
    dout       = '0;
    dout_valid = 1'b0;
    dout_sop   = 1'b0;
    dout_eop   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        hdr_rdreq = start_ev;
      end
      S_HDR_SEND: begin
        dout_valid = 1'b1;
        dout       = hdr_word;
        dout_sop   = (k_q == '0);
      end
      S_DATA_SEND: begin
        dout_valid = 1'b1;
        dout       = smp_q;
        dout_eop   = last_smp;
      end
      S_DONE: begin
        wvb_rddone = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy        = (state_q != S_IDLE);
  assign wvb_rd_addr = ptr_q;

  // Datapath next-state: header latch, read pointer, counters, sample.
  always_comb begin
    hdr_d = hdr_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    k_d   = k_q;
    smp_d = smp_q;
    unique case (state_q)
      S_HDR_WAIT: begin
        hdr_d = hdr_data;
        ptr_d = hdr_start;
        cnt_d = nwords;
        k_d   = '0;
      end
      S_HDR_SEND: begin
        if (xfer) k_d = k_q + 1'b1;
      end
      S_DATA_WAIT: begin
        smp_d = wvb_rd_data;
      end
      S_DATA_SEND: begin
        if (xfer) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      k_q   <= '0;
      smp_q <= '0;
    end else begin
      hdr_q <= hdr_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      k_q   <= k_d;
      smp_q <= smp_d;
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// tb_wvb_reader: directed bench for wvb_reader.
// Header FIFO and RAM models; RAM word at address a is 0xA000|a.
`timescale 1ns/1ps
module tb_wvb_reader;

  localparam int AW = 12;
  localparam int HW = 80;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          hdr_empty;
  logic          hdr_rdreq;
  logic [HW-1:0] hdr_data = '0;
  logic [AW-1:0] wvb_rd_addr;
  logic [DW-1:0] wvb_rd_data = '0;
  logic          wvb_rddone;
  logic [15:0]   dout;
  logic          dout_valid;
  logic          dout_ready = 1'b1;
  logic          dout_sop;
  logic          dout_eop;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int gcyc = 0;

  logic [HW-1:0] hq [16];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int last_req = -100;
  int last_done = -100;
  int req_gap = 0;

  always #5 clk = ~clk;

  wvb_reader #(
    .P_ADR_WIDTH (AW),
    .P_HDR_WIDTH (HW),
    .P_DATA_WIDTH(DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .hdr_empty  (hdr_empty),
    .hdr_rdreq  (hdr_rdreq),
    .hdr_data   (hdr_data),
    .wvb_rd_addr(wvb_rd_addr),
    .wvb_rd_data(wvb_rd_data),
    .wvb_rddone (wvb_rddone),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sop   (dout_sop),
    .dout_eop   (dout_eop),
    .busy       (busy)
  );

  always @(posedge clk) gcyc <= gcyc + 1;

  always @(posedge clk) wvb_rd_data <= 16'hA000 | 16'(wvb_rd_addr);

  always @(posedge clk) begin
    if (hdr_rdreq) begin
      hdr_data <= hq[rd_cnt % 16];
      rd_cnt   <= rd_cnt + 1;
    end
  end

  assign hdr_empty = (rd_cnt == wr_cnt);

  always @(negedge clk) begin
    if (wvb_rddone) last_done = gcyc;
    if (hdr_rdreq) begin
      req_gap  = gcyc - last_done;
      last_req = gcyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_hdr(input logic [11:0] st, input logic [11:0] sp,
                          input logic [55:0] opq);
    @(posedge clk);
    #1;
    hq[wr_cnt % 16] = {opq, st, sp};
    wr_cnt++;
  endtask

  task automatic run_event(input logic [11:0] st, input logic [11:0] sp,
                           input logic [55:0] opq, input bit rnd,
                           input bit drop_en);
    logic [79:0] h;
    logic [11:0] a;
    logic [15:0] ew;
    logic [15:0] hd;
    logic hs, he;
    int n, total, idx, cyc, budget;
    bit first, hold, want_done, fin;
    h = {opq, st, sp};
    n = int'(12'(sp - st)) + 1;
    total = 5 + n;
    budget = 10 * total + 100;
    idx = 0; cyc = 0;
    first = 1; hold = 0; want_done = 0; fin = 0;
    hd = '0; hs = 0; he = 0;
    @(posedge clk);
    #1;
    en = 1'b1;
    while (!fin && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        chk("hold_valid", 32'(dout_valid), 1);
        chk("hold_dout", 32'(dout), 32'(hd));
        chk("hold_sop", 32'(dout_sop), 32'(hs));
        chk("hold_eop", 32'(dout_eop), 32'(he));
      end
      hold = 0;
      if (want_done) begin
        chk("rddone", 32'(wvb_rddone), 1);
        fin = 1;
      end else begin
        if (wvb_rddone) chk("early_rddone", 32'(wvb_rddone), 0);
        if (dout_valid) begin
          if (first) begin
            chk("latency", 32'(gcyc - last_req), 2);
            first = 0;
          end
          if (dout_ready) begin
            if (idx < 5) begin
              ew = 16'(h >> (16 * (4 - idx)));
            end else begin
              a  = st + 12'(idx - 5);
              ew = 16'hA000 | 16'(a);
            end
            chk("word", 32'(dout), 32'(ew));
            chk("sop", 32'(dout_sop), 32'(idx == 0));
            chk("eop", 32'(dout_eop), 32'(idx == total - 1));
            idx++;
            if (idx == total) want_done = 1;
            if (drop_en && idx == 3) en = 1'b0;
          end else begin
            hold = 1;
            hd = dout;
            hs = dout_sop;
            he = dout_eop;
          end
        end
      end
      @(posedge clk);
      #1;
      dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk("event_timeout", 32'(fin), 1);
    chk("word_count", 32'(idx), 32'(total));
    @(negedge clk);
    chk("rddone_pulse", 32'(wvb_rddone), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdreq"}, 32'(hdr_rdreq), 0);
    chk({tag, "_addr"}, 32'(wvb_rd_addr), 0);
    chk({tag, "_rddone"}, 32'(wvb_rddone), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_valid"}, 32'(dout_valid), 0);
    chk({tag, "_sop"}, 32'(dout_sop), 0);
    chk({tag, "_eop"}, 32'(dout_eop), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int cnt;
    int rc;
    bit reached;

    #12;
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic event 0x010..0x013
    push_hdr(12'h010, 12'h013, 56'h11223344556677);
    run_event(12'h010, 12'h013, 56'h11223344556677, 0, 0);

    // Address wrap 0xFFE..0x001
    push_hdr(12'hFFE, 12'h001, 56'hA1A2A3A4A5A6A7);
    run_event(12'hFFE, 12'h001, 56'hA1A2A3A4A5A6A7, 0, 0);

    // Full buffer, 4096 samples
    push_hdr(12'h005, 12'h004, 56'hDEADBEEF012345);
    run_event(12'h005, 12'h004, 56'hDEADBEEF012345, 0, 0);

    // Backpressure, plus a single-sample event
    push_hdr(12'h020, 12'h02F, 56'h0F0E0D0C0B0A09);
    run_event(12'h020, 12'h02F, 56'h0F0E0D0C0B0A09, 1, 0);
    push_hdr(12'h123, 12'h123, 56'h55AA55AA55AA55);
    run_event(12'h123, 12'h123, 56'h55AA55AA55AA55, 1, 0);

    // Back-to-back events
    push_hdr(12'h040, 12'h042, 56'h01010101010101);
    push_hdr(12'h300, 12'h300, 56'h02020202020202);
    run_event(12'h040, 12'h042, 56'h01010101010101, 0, 0);
    run_event(12'h300, 12'h300, 56'h02020202020202, 0, 0);
    chk("b2b_gap", 32'(req_gap), 1);

    // en dropped mid-event: event completes, no further pop
    push_hdr(12'h050, 12'h053, 56'h03030303030303);
    push_hdr(12'h060, 12'h061, 56'h04040404040404);
    run_event(12'h050, 12'h053, 56'h03030303030303, 0, 1);
    rc = rd_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("noen_rdreq", 32'(hdr_rdreq), 0);
      chk("noen_busy", 32'(busy), 0);
    end
    chk("noen_popcnt", 32'(rd_cnt), 32'(rc));
    run_event(12'h060, 12'h061, 56'h04040404040404, 0, 0);

    // Reset in the middle of sample streaming
    push_hdr(12'h100, 12'h1FF, 56'h06060606060606);
    en = 1'b1;
    dout_ready = 1'b1;
    cnt = 0;
    reached = 0;
    for (int i = 0; i < 200 && !reached; i++) begin
      @(negedge clk);
      if (dout_valid && cnt >= 7) begin
        reached = 1;
      end else if (dout_valid && dout_ready) begin
        cnt++;
      end
    end
    chk("rst_reach", 32'(reached), 1);
    en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_rddone", 32'(wvb_rddone), 0);
      chk("midrst_busy", 32'(busy), 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_hdr(12'h200, 12'h203, 56'h07070707070707);
    run_event(12'h200, 12'h203, 56'h07070707070707, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
